// File: rtl/pcie_bram_fifo_ctl_s6.sv
// pcie_bram_fifo_ctl_s6
//   FIFO controller for one Spartan-6 PCIe BRAM wrapper. Port A writes and
//   port B reads. A valid/ready write stream becomes BRAM writes. Reads are
//   issued ahead into a 4-entry skid buffer, so the 1- or 2-cycle BRAM read
//   latency is hidden and the output can deliver one word per cycle.
// Ports
//   user_clk_i, reset_i (async, active high), flush_i (sync discard-all)
//   in_valid_i / in_ready_o / in_data_i     write stream
//   out_valid_o / out_ready_i / out_data_o  read stream (skid head)
//   level_o                                  words held (BRAM + in flight + skid)
//   bram_*                                   BRAM wrapper port A/B controls
module pcie_bram_fifo_ctl_s6 #(
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned DOB_REG    = 1
) (
  input  logic                  user_clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [DEPTH_LOG2+1:0] level_o,
  output logic                  bram_wen_o,
  output logic [11:0]           bram_waddr_o,
  output logic [WIDTH-1:0]      bram_wdata_o,
  output logic                  bram_ren_o,
  output logic                  bram_rce_o,
  output logic [11:0]           bram_raddr_o,
  input  logic [WIDTH-1:0]      bram_rdata_i
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam int unsigned LW = DEPTH_LOG2 + 2;

  function automatic int unsigned max_depth_log2(input int unsigned w);
    case (w)
      4:       return 12;
      9:       return 11;
      18:      return 10;
      36:      return 9;
      default: return 0;
    endcase
  endfunction

  if (max_depth_log2(WIDTH) == 0 || DEPTH_LOG2 > max_depth_log2(WIDTH)) begin : g_bad_params
    $fatal(1, "pcie_bram_fifo_ctl_s6: illegal WIDTH=%0d / DEPTH_LOG2=%0d", WIDTH, DEPTH_LOG2);
  end

  logic                  run_q, run_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ren_q, ren_d;
  logic [DEPTH_LOG2-1:0] raddr_q, raddr_d;
  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic [WIDTH-1:0]      skid_q [4];
  logic [WIDTH-1:0]      skid_d [4];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [LW-1:0]         level_q, level_d;

  logic [PW-1:0] used;
  logic          full;
  logic          in_rdy;
  logic          wr_fire;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    outst;

  always_comb begin
    // used can reach 2^DEPTH_LOG2 but never exceed it, so its top bit is "full"
    used    = wr_ptr_q - rd_ptr_q;
    full    = used[DEPTH_LOG2];
    in_rdy  = run_q & ~full & ~flush_i;
    wr_fire = in_valid_i & in_rdy;
    pop     = (cnt_q != 3'd0) & out_ready_i;
    push    = (DOB_REG != 0) ? v2_q : v1_q;
    // Credits: every read already issued but not yet popped owns a skid slot,
    // counted after this cycle's pop so a steady stream keeps issuing.
    outst   = {2'b00, ren_q} + {2'b00, v1_q}
            + ((DOB_REG != 0) ? {2'b00, v2_q} : 3'd0)
            + cnt_q - {2'b00, pop};

    run_d    = 1'b1;
    wr_ptr_d = wr_ptr_q + PW'(wr_fire);
    // Compare against the post-write pointer: the BRAM write lands on this
    // edge, so the read issued next cycle sees it.
    issue    = (rd_ptr_q != wr_ptr_d) & (outst < 3'd4) & ~flush_i;
    rd_ptr_d = rd_ptr_q + PW'(issue);
    ren_d    = issue;
    raddr_d  = issue ? rd_ptr_q[DEPTH_LOG2-1:0] : raddr_q;
    v1_d     = ren_q;
    v2_d     = v1_q;

    skid_d = skid_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) begin
      skid_d[tail_q] = bram_rdata_i;
      tail_d         = tail_q + 2'd1;
    end
    if (pop) begin
      head_d = head_q + 2'd1;
    end
    cnt_d   = cnt_q + {2'b00, push} - {2'b00, pop};
    level_d = level_q + LW'(wr_fire) - LW'(pop);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ren_d    = 1'b0;
      v1_d     = 1'b0;
      v2_d     = 1'b0;
      head_d   = '0;
      tail_d   = '0;
      cnt_d    = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge user_clk_i or posedge reset_i) begin
    if (reset_i) begin
      run_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ren_q    <= 1'b0;
      raddr_q  <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        skid_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
    end else begin
      run_q    <= run_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ren_q    <= ren_d;
      raddr_q  <= raddr_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      for (int unsigned i = 0; i < 4; i++) begin
        skid_q[i] <= skid_d[i];
      end
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
    end
  end

  assign in_ready_o   = in_rdy;
  assign bram_wen_o   = wr_fire;
  assign bram_wdata_o = in_data_i;
  assign bram_waddr_o = 12'(wr_ptr_q[DEPTH_LOG2-1:0]);
  assign bram_ren_o   = ren_q;
  assign bram_raddr_o = 12'(raddr_q);
  assign bram_rce_o   = (DOB_REG != 0) ? v1_q : 1'b0;
  assign out_valid_o  = (cnt_q != 3'd0);
  assign out_data_o   = skid_q[head_q];
  assign level_o      = level_q;

endmodule

// File: tb/tb_pcie_bram_fifo_ctl_s6.sv
module tb_pcie_bram_fifo_ctl_s6;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [35:0] in_data;

  // DUT A: WIDTH 36, DEPTH_LOG2 9, DOB_REG 1
  logic        a_in_ready, a_out_valid, a_wen, a_ren, a_rce;
  logic [35:0] a_out_data, a_wdata, a_rdata, a_lat;
  logic [10:0] a_level;
  logic [11:0] a_waddr, a_raddr;
  // DUT B: WIDTH 18, DEPTH_LOG2 4, DOB_REG 0
  logic        b_in_ready, b_out_valid, b_wen, b_ren, b_rce;
  logic [17:0] b_out_data, b_wdata, b_rdata;
  logic [5:0]  b_level;
  logic [11:0] b_waddr, b_raddr;

  logic [35:0] mem_a [512];
  logic [17:0] mem_b [16];

  int n_cmp;
  int n_err;
  int cyc;
  int pops_a, pops_b, acc_a;
  int lv_a, lv_b;
  logic [35:0] q_a[$];
  logic [17:0] q_b[$];

  pcie_bram_fifo_ctl_s6 #(.WIDTH(36), .DEPTH_LOG2(9), .DOB_REG(1)) u_a (
    .user_clk_i(clk), .reset_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
    .level_o(a_level),
    .bram_wen_o(a_wen), .bram_waddr_o(a_waddr), .bram_wdata_o(a_wdata),
    .bram_ren_o(a_ren), .bram_rce_o(a_rce), .bram_raddr_o(a_raddr),
    .bram_rdata_i(a_rdata)
  );

  pcie_bram_fifo_ctl_s6 #(.WIDTH(18), .DEPTH_LOG2(4), .DOB_REG(0)) u_b (
    .user_clk_i(clk), .reset_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data[17:0]),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
    .level_o(b_level),
    .bram_wen_o(b_wen), .bram_waddr_o(b_waddr), .bram_wdata_o(b_wdata),
    .bram_ren_o(b_ren), .bram_rce_o(b_rce), .bram_raddr_o(b_raddr),
    .bram_rdata_i(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM wrapper models
  initial begin
    a_lat = '0; a_rdata = '0; b_rdata = '0;
  end
  always @(posedge clk) begin
    if (a_wen) mem_a[a_waddr[8:0]] <= a_wdata;
    if (a_ren) a_lat <= mem_a[a_raddr[8:0]];
    if (a_rce) a_rdata <= a_lat;
    if (b_wen) mem_b[b_waddr[3:0]] <= b_wdata;
    if (b_ren) b_rdata <= mem_b[b_raddr[3:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pushes accepted words, pops/compares delivered words.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q_a.delete(); q_b.delete(); lv_a = 0; lv_b = 0;
    end else begin
      check("level_a", 64'(a_level), 64'(lv_a));
      check("level_b", 64'(b_level), 64'(lv_b));
      check("level_a_bound", 64'(a_level <= 11'd516), 64'd1);
      if (flush) begin
        q_a.delete(); q_b.delete(); lv_a = 0; lv_b = 0;
      end else begin
        if (a_out_valid && out_ready) begin
          if (q_a.size() == 0) check("pop_a_unexpected", 64'd1, 64'd0);
          else check("data_a", 64'(a_out_data), 64'(q_a.pop_front()));
          lv_a--; pops_a++;
        end
        if (b_out_valid && out_ready) begin
          if (q_b.size() == 0) check("pop_b_unexpected", 64'd1, 64'd0);
          else check("data_b", 64'(b_out_data), 64'(q_b.pop_front()));
          lv_b--; pops_b++;
        end
        if (in_valid && a_in_ready) begin
          q_a.push_back(in_data); lv_a++; acc_a++;
        end
        if (in_valid && b_in_ready) begin
          q_b.push_back(in_data[17:0]); lv_b++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((a_level != 0 || b_level != 0 || a_out_valid || b_out_valid) && t < 3000) begin
      tick();
      t++;
    end
    check(name, 64'(t < 3000), 64'd1);
    tick();
  endtask

  task automatic fill_full(input string tag);
    int a0;
    a0 = acc_a;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 600; i++) begin
      in_data = 36'(i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_accepted_a"}, 64'(acc_a - a0), 64'd516);
    check({tag, "_in_ready_a"}, 64'(a_in_ready), 64'd0);
    check({tag, "_level_a"}, 64'(a_level), 64'd516);
    check({tag, "_level_b"}, 64'(b_level), 64'd20);
    // A pop alone does not free space; the following read issue does.
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_pop_ready_a"}, 64'(a_in_ready), 64'd0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_issue_ready_a"}, 64'(a_in_ready), 64'd1);
    check({tag, "_level_after_pop"}, 64'(a_level), 64'd515);
    tick();
    drain({tag, "_drain"});
  endtask

  initial begin
    int p0a, p0b, gap_a, gap_b;
    bit seen_a, seen_b;
    n_cmp = 0; n_err = 0; cyc = 0;
    pops_a = 0; pops_b = 0; acc_a = 0; lv_a = 0; lv_b = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_in_ready_a", 64'(a_in_ready), 0);
    check("rst_in_ready_b", 64'(b_in_ready), 0);
    check("rst_out_valid_a", 64'(a_out_valid), 0);
    check("rst_level_a", 64'(a_level), 0);
    check("rst_wen_a", 64'(a_wen), 0);
    check("rst_ren_a", 64'(a_ren), 0);
    check("rst_rce_a", 64'(a_rce), 0);
    check("rst_waddr_a", 64'(a_waddr), 0);
    check("rst_raddr_a", 64'(a_raddr), 0);
    check("rst_out_data_a", 64'(a_out_data), 0);
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", 64'(a_in_ready), 0);
    tick();
    check("in_ready_after_edge_a", 64'(a_in_ready), 1);
    check("in_ready_after_edge_b", 64'(b_in_ready), 1);

    // Single word latency: A valid in W+4, B valid in W+3
    out_ready = 1'b1;
    in_data   = 36'h9_DEAD_BEEF;
    in_valid  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("sw_wen_a", 64'(a_wen), 1);
        check("sw_waddr_a", 64'(a_waddr), 0);
      end
      if (k == 1) begin
        check("sw_ren_a", 64'(a_ren), 1);
        check("sw_raddr_hi_a", 64'(a_raddr[11:9]), 0);
      end
      if (k == 2) begin
        check("sw_rce_a", 64'(a_rce), 1);
        check("sw_rce_b", 64'(b_rce), 0);
      end
      check("sw_latency_a", 64'(a_out_valid), 64'(k == 4));
      check("sw_latency_b", 64'(b_out_valid), 64'(k == 3));
      tick();
      if (k == 0) in_valid = 1'b0;
    end
    @(negedge clk);
    check("sw_level_end", 64'(a_level), 0);
    tick();

    // Streaming: no gaps after the first word
    p0a = pops_a; p0b = pops_b; gap_a = 0; gap_b = 0; seen_a = 0; seen_b = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 220; i++) begin
      in_valid = (i < 200);
      in_data  = 36'(i + 36'h1_0000_0000);
      @(negedge clk);
      if (a_out_valid) seen_a = 1;
      else if (seen_a && (pops_a - p0a) < 200) gap_a++;
      if (b_out_valid) seen_b = 1;
      else if (seen_b && (pops_b - p0b) < 200) gap_b++;
      tick();
    end
    in_valid = 1'b0;
    check("stream_count_a", 64'(pops_a - p0a), 200);
    check("stream_count_b", 64'(pops_b - p0b), 200);
    check("stream_gaps_a", 64'(gap_a), 0);
    check("stream_gaps_b", 64'(gap_b), 0);

    // Full, drain, and a second fill to exercise pointer wrap
    fill_full("fill1");
    fill_full("fill2");

    // Random backpressure
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 50);
      in_data   = {4'($urandom_range(0, 15)), 32'($urandom)};
      tick();
    end
    drain("random_drain");

    // Flush with reads in flight and a partly full skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 36'(36'h5_0000_0000 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_cycle_out_valid_a", 64'(a_out_valid), 1);
    check("flush_cycle_in_ready_a", 64'(a_in_ready), 0);
    check("flush_cycle_in_ready_b", 64'(b_in_ready), 0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_flush_valid_a", 64'(a_out_valid), 0);
      check("post_flush_valid_b", 64'(b_out_valid), 0);
      check("post_flush_level_a", 64'(a_level), 0);
      tick();
    end
    in_data  = 36'h1234;
    in_valid = 1'b1;
    tick();
    drain("flush_1234_drain");

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 36'(36'h7_0000_0000 + i);
      tick();
    end
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async_rst_valid_a", 64'(a_out_valid), 0);
    check("async_rst_valid_b", 64'(b_out_valid), 0);
    check("async_rst_level_a", 64'(a_level), 0);
    check("async_rst_in_ready_a", 64'(a_in_ready), 0);
    repeat (2) tick();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      check("after_rst_valid_a", 64'(a_out_valid), 0);
      check("after_rst_valid_b", 64'(b_out_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
